alu_pipe: RTL

Parametrised, handshaked successor to the team's single-cycle 16-bit ALU. It keeps the eight-operation opcode set, corrects the arithmetic-shift and zero-flag behaviour, adds full N/Z/C/V flags, and adds an iterative multi-cycle multiply. It sits between the register-read stage and the writeback stage of the processor datapath. Valid/ready handshakes on both sides let it absorb writeback stalls and its own multi-cycle operations.

---
 rtl/alu_pipe_if.sv | 29 ++
 rtl/alu_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
// Handshaked operation/result bundle for alu_pipe.
// The master drives operations and consumes results; alu_pipe is the slave.
interface alu_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
    );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with N/Z/C/V flags and an iterative shift-add multiply.
// Single-cycle ops land in the output register on the accept edge; MUL takes WIDTH extra edges.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_pipe_if.slave  bus
);
    localparam int               MSB  = WIDTH - 1;
    localparam logic [WIDTH-1:0] WVAL = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHR  = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_DIR  = 4'd6;
    localparam logic [3:0] OP_SAR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state;
    logic [SHW-1:0]       cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   prod;

    logic                 accept;
    logic                 mul_done;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [WIDTH:0]       ext_r;
    logic [WIDTH:0]       ext_l;
    logic [WIDTH:0]       ext_s;
    logic [SHW:0]         amt;
    logic                 in_range;
    logic [WIDTH-1:0]     res_c;
    logic                 c_c;
    logic                 v_c;
    logic                 err_c;

    assign bus.in_ready = (state != MUL) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_done     = (state == MUL) && (cnt == SHW'(WIDTH - 1));
    assign prod         = acc + (mplier[0] ? mcand : '0);

    // Shifts run on a WIDTH+1 bit value with a guard bit so the last bit out
    // falls into the guard position; b == WIDTH is covered by the same path.
    always_comb begin
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        diff     = {1'b0, bus.a} - {1'b0, bus.b};
        in_range = (bus.b <= WVAL);
        amt      = in_range ? bus.b[SHW:0] : '0;
        ext_r    = {bus.a, 1'b0} >> amt;
        ext_l    = {1'b0, bus.a} << amt;
        ext_s    = $signed({bus.a, 1'b0}) >>> amt;
        res_c    = '0;
        c_c      = 1'b0;
        v_c      = 1'b0;
        err_c    = 1'b0;
        case (bus.op)
            OP_ADD: begin
                res_c = sum[MSB:0];
                c_c   = sum[WIDTH];
                v_c   = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                res_c = diff[MSB:0];
                c_c   = diff[WIDTH];
                v_c   = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
            end
            OP_SHR:  if (in_range) {res_c, c_c} = ext_r;
            OP_SHL:  if (in_range) {c_c, res_c} = ext_l;
            OP_SAR: begin
                if (in_range) {res_c, c_c} = ext_s;
                else          res_c = {WIDTH{bus.a[MSB]}};
            end
            OP_NAND: res_c = ~(bus.a & bus.b);
            OP_OR:   res_c = bus.a | bus.b;
            OP_DIR:  res_c = bus.a;
            OP_MUL:  res_c = '0;
            default: err_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flag_z    <= 1'b0;
            bus.flag_n    <= 1'b0;
            bus.flag_c    <= 1'b0;
            bus.flag_v    <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && bus.op == OP_MUL) begin
                        state  <= MUL;
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, bus.a};
                        mplier <= bus.b;
                    end
                end
                MUL: begin
                    acc    <= prod;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (mul_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (mul_done) begin
                bus.out_valid <= 1'b1;
                bus.result    <= prod[MSB:0];
                bus.flag_z    <= (prod[MSB:0] == '0);
                bus.flag_n    <= prod[MSB];
                bus.flag_c    <= |prod[2*WIDTH-1:WIDTH];
                bus.flag_v    <= 1'b0;
                bus.err       <= 1'b0;
            end else if (accept && bus.op != OP_MUL) begin
                bus.out_valid <= 1'b1;
                bus.result    <= res_c;
                bus.flag_z    <= (res_c == '0);
                bus.flag_n    <= res_c[MSB];
                bus.flag_c    <= c_c;
                bus.flag_v    <= v_c;
                bus.err       <= err_c;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
